// File: rtl/common_pkg.sv
// common_pkg: shared RV32I decode types, opcode constants, control decode and immediate generation.
package common_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {ENC_R, ENC_I, ENC_S, ENC_B, ENC_U, ENC_J} encoding_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_t;

    typedef struct packed {
        encoding_e             encoding;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src;
        logic [2:0]            funct3;
        logic                  funct7_b5;
        logic [REG_ADDR_W-1:0] write_back_id;
    } control_t;

    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     read1;
        logic [DATA_W-1:0]     read2;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        control_t              control;
    } id_ex_t;

    function automatic control_t control_decode(input logic [6:0] opcode, input logic [2:0] funct3,
                                                input logic funct7_b5, input logic [4:0] rd);
        control_t c;
        c               = '0;
        c.encoding      = ENC_R;
        c.funct3        = funct3;
        c.funct7_b5     = funct7_b5;
        c.write_back_id = rd;
        case (opcode)
            OP_R:      c.reg_write = 1'b1;
            OP_IMM:    begin c.encoding = ENC_I; c.reg_write = 1'b1; c.alu_src = 1'b1; end
            OP_LOAD:   begin c.encoding = ENC_I; c.reg_write = 1'b1; c.alu_src = 1'b1; c.mem_read = 1'b1; end
            OP_STORE:  begin c.encoding = ENC_S; c.alu_src = 1'b1; c.mem_write = 1'b1; end
            OP_BRANCH: begin c.encoding = ENC_B; c.branch = 1'b1; end
            OP_LUI,
            OP_AUIPC:  begin c.encoding = ENC_U; c.reg_write = 1'b1; c.alu_src = 1'b1; end
            OP_JAL:    begin c.encoding = ENC_J; c.reg_write = 1'b1; c.jump = 1'b1; end
            OP_JALR:   begin c.encoding = ENC_I; c.reg_write = 1'b1; c.jump = 1'b1; c.alu_src = 1'b1; end
            default:   c.encoding = ENC_R;
        endcase
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] imm_gen(input logic [31:7] w, input encoding_e enc);
        return (enc == ENC_I) ? {{20{w[31]}}, w[31:20]} :
               (enc == ENC_S) ? {{20{w[31]}}, w[31:25], w[11:7]} :
               (enc == ENC_B) ? {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0} :
               (enc == ENC_U) ? {w[31:12], 12'b0} :
               (enc == ENC_J) ? {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0} : '0;
    endfunction
endpackage

// File: rtl/decode_issue_stage_hazard.sv
// id_hazard_unit: combinational load-use detection between the held instruction and the incoming one.
module id_hazard_unit
    import common_pkg::*;
(
    input  logic                  i_out_valid,
    input  logic                  i_mem_read,
    input  logic                  i_reg_write,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  encoding_e             i_enc,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic                  o_hazard
);
    logic w_use1, w_use2;

    assign w_use1   = (i_enc != ENC_U) && (i_enc != ENC_J);
    assign w_use2   = (i_enc == ENC_R) || (i_enc == ENC_S) || (i_enc == ENC_B);
    assign o_hazard = i_out_valid & i_mem_read & i_reg_write & (i_rd != '0)
                    & ((w_use1 & (i_rd == i_rs1)) | (w_use2 & (i_rd == i_rs2)));
endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: registered RV32I decode with bypassed register file and valid/ready output.
// Load-use stalling and the stall counter exist only when ID_LOAD_USE_STALL_EN is defined.
module decode_issue_stage
    import common_pkg::*;
#(
    parameter  int XLEN      = DATA_W,
    parameter  int REG_COUNT = 32,
    parameter  int PERF_W    = 32,
    localparam int RAW       = $clog2(REG_COUNT)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  instruction_t      i_instruction,
    input  logic [XLEN-1:0]   i_pc,
    input  logic              i_flush,
    input  logic              i_wb_en,
    input  logic [RAW-1:0]    i_wb_id,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [XLEN-1:0]   o_out_pc,
    output logic [XLEN-1:0]   o_out_imm,
    output control_t          o_out_control,
    output logic [XLEN-1:0]   o_out_read1,
    output logic [XLEN-1:0]   o_out_read2,
    output logic [RAW-1:0]    o_out_rs1,
    output logic [RAW-1:0]    o_out_rs2,
    output logic [PERF_W-1:0] o_perf_stall_cnt
);
    logic [XLEN-1:0] r_regs [REG_COUNT];
    logic            r_valid;
    id_ex_t          r_ex;
    id_ex_t          w_ex;
    control_t        w_ctrl;
    logic [31:0]     w_ins;
    logic [RAW-1:0]  w_rs1, w_rs2;
    logic [XLEN-1:0] w_read1, w_read2;
    logic            w_hazard, w_accept;

    assign w_ins      = i_instruction;
    assign w_rs1      = w_ins[15 +: RAW];
    assign w_rs2      = w_ins[20 +: RAW];
    assign w_ctrl     = control_decode(w_ins[6:0], w_ins[14:12], w_ins[30], w_ins[11:7]);
    assign w_read1    = (w_rs1 == '0) ? '0 : (i_wb_en && i_wb_id == w_rs1) ? i_wb_data : r_regs[w_rs1];
    assign w_read2    = (w_rs2 == '0) ? '0 : (i_wb_en && i_wb_id == w_rs2) ? i_wb_data : r_regs[w_rs2];
    assign o_in_ready = i_rst & ~i_flush & ~w_hazard & (~r_valid | i_out_ready);
    assign w_accept   = i_in_valid & o_in_ready;

    // assemble the decoded bundle the output register captures on accept
    always_comb begin
        w_ex         = '0;
        w_ex.pc      = i_pc;
        w_ex.imm     = imm_gen(w_ins[31:7], w_ctrl.encoding);
        w_ex.read1   = w_read1;
        w_ex.read2   = w_read2;
        w_ex.rs1     = w_rs1;
        w_ex.rs2     = w_rs2;
        w_ex.control = w_ctrl;
    end

    // register file: cleared on reset, writes to x0 dropped; write lands even during a flush
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < REG_COUNT; k++) r_regs[k] <= '0;
        end else if (i_wb_en && i_wb_id != '0) begin
            r_regs[i_wb_id] <= i_wb_data;
        end
    end

    // output register: flush kills it, accept loads it, consumption without refill empties it
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_valid <= 1'b0;
            r_ex    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_ex    <= w_ex;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef ID_LOAD_USE_STALL_EN
    logic [PERF_W-1:0] r_stall_cnt;

    id_hazard_unit u_hazard (
        .i_out_valid (r_valid),
        .i_mem_read  (r_ex.control.mem_read),
        .i_reg_write (r_ex.control.reg_write),
        .i_rd        (r_ex.control.write_back_id),
        .i_enc       (w_ctrl.encoding),
        .i_rs1       (w_rs1),
        .i_rs2       (w_rs2),
        .o_hazard    (w_hazard)
    );

    // saturating count of cycles where a presented instruction is held back by a load-use hazard
    always_ff @(posedge i_clk) begin
        if (!i_rst) r_stall_cnt <= '0;
        else if (w_hazard && i_in_valid && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign o_perf_stall_cnt = r_stall_cnt;
`else
    assign w_hazard         = 1'b0;
    assign o_perf_stall_cnt = '0;
`endif

    assign o_out_valid   = r_valid;
    assign o_out_pc      = r_ex.pc;
    assign o_out_imm     = r_ex.imm;
    assign o_out_control = r_ex.control;
    assign o_out_read1   = r_ex.read1;
    assign o_out_read2   = r_ex.read2;
    assign o_out_rs1     = r_ex.rs1;
    assign o_out_rs2     = r_ex.rs2;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed vectors with a scoreboard queue checked by an output monitor.
module tb_decode_issue_stage;
    import common_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } exp_t;

`ifdef ID_LOAD_USE_STALL_EN
    localparam int EXP_STALL = 1;
`else
    localparam int EXP_STALL = 0;
`endif

    logic         i_clk, i_rst, i_in_valid, o_in_ready, i_flush, i_wb_en, o_out_valid, i_out_ready;
    instruction_t i_instruction;
    logic [31:0]  i_pc, i_wb_data, o_out_pc, o_out_imm, o_out_read1, o_out_read2, o_perf_stall_cnt;
    logic [4:0]   i_wb_id, o_out_rs1, o_out_rs2;
    control_t     o_out_control;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   st;
    logic va;

    decode_issue_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_instruction(i_instruction), .i_pc(i_pc), .i_flush(i_flush), .i_wb_en(i_wb_en),
        .i_wb_id(i_wb_id), .i_wb_data(i_wb_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_pc(o_out_pc), .o_out_imm(o_out_imm), .o_out_control(o_out_control),
        .o_out_read1(o_out_read1), .o_out_read2(o_out_read2), .o_out_rs1(o_out_rs1),
        .o_out_rs2(o_out_rs2), .o_perf_stall_cnt(o_perf_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // present one instruction (optionally with a write-back) until accepted; expectation queued at accept
    task automatic issue(input logic [31:0] ins, input logic [31:0] p, input logic we, input logic [4:0] wid,
                         input logic [31:0] wd, input exp_t ex, output int stalls, output logic v_at_acc);
        i_in_valid    = 1'b1;
        i_instruction = instruction_t'(ins);
        i_pc          = p;
        i_wb_en       = we;
        i_wb_id       = wid;
        i_wb_data     = wd;
        stalls        = 0;
        v_at_acc      = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_in_ready) begin
                v_at_acc = o_out_valid;
                sb.push_back(ex);
                break;
            end
            stalls++;
            if (stalls > 20) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: pc %h not accepted within 20 cycles", p);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        i_wb_en    = 1'b0;
    endtask

    task automatic wb_cycle(input logic [4:0] id, input logic [31:0] d);
        i_wb_en   = 1'b1;
        i_wb_id   = id;
        i_wb_data = d;
        @(posedge i_clk);
        #1;
        i_wb_en = 1'b0;
    endtask

    // monitor: every consumed output is matched against the oldest expectation
    always @(negedge i_clk) begin
        if (i_rst && o_out_valid && i_out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got pc %h expected no output", o_out_pc);
            end else begin
                e = sb.pop_front();
                chk("out_pc", o_out_pc, e.pc);
                chk("out_imm", o_out_imm, e.imm);
                chk("out_read1", o_out_read1, e.r1);
                chk("out_read2", o_out_read2, e.r2);
                chk("out_rs1", {27'd0, o_out_rs1}, {27'd0, e.rs1});
                chk("out_rs2", {27'd0, o_out_rs2}, {27'd0, e.rs2});
                chk("out_rd", {27'd0, o_out_control.write_back_id}, {27'd0, e.rd});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        i_rst         = 1'b0;
        i_in_valid    = 1'b1;
        i_instruction = instruction_t'(32'h00500093);
        i_pc          = 32'h0;
        i_flush       = 1'b0;
        i_wb_en       = 1'b0;
        i_wb_id       = 5'd0;
        i_wb_data     = 32'h0;
        i_out_ready   = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_out_valid", {31'd0, o_out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, o_in_ready}, 32'd0);
        chk("reset_perf", o_perf_stall_cnt, 32'd0);
        chk("reset_out_pc", o_out_pc, 32'd0);
        @(posedge i_clk);
        #1;
        i_rst      = 1'b1;
        i_in_valid = 1'b0;

        // addi x1,x0,5
        issue(32'h00500093, 32'h100, 1'b0, 5'd0, 32'h0,
              '{32'h100, 32'h5, 32'h0, 32'h0, 5'd0, 5'd5, 5'd1}, st, va);
        wb_cycle(5'd1, 32'h11111111);
        // add x4,x3,x3 with same-cycle write-back of x3
        issue(32'h00318233, 32'h104, 1'b1, 5'd3, 32'hDEADBEEF,
              '{32'h104, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 5'd3, 5'd3, 5'd4}, st, va);
        // lw x5,0(x2) followed by dependent add x6,x5,x1
        issue(32'h00012283, 32'h108, 1'b0, 5'd0, 32'h0,
              '{32'h108, 32'h0, 32'h0, 32'h0, 5'd2, 5'd0, 5'd5}, st, va);
        issue(32'h00128333, 32'h10C, 1'b0, 5'd0, 32'h0,
              '{32'h10C, 32'h0, 32'h0, 32'h11111111, 5'd5, 5'd1, 5'd6}, st, va);
        chk("load_use_stall_cycles", st, EXP_STALL);
        chk("load_use_valid_at_accept", {31'd0, va}, (EXP_STALL == 1) ? 32'd0 : 32'd1);
        @(negedge i_clk);
        chk("perf_stall_cnt", o_perf_stall_cnt, EXP_STALL);
        @(posedge i_clk);
        #1;
        // sw x3,-4(x1) then hold it under backpressure
        issue(32'hFE30AE23, 32'h110, 1'b0, 5'd0, 32'h0,
              '{32'h110, 32'hFFFFFFFC, 32'h11111111, 32'hDEADBEEF, 5'd1, 5'd3, 5'd28}, st, va);
        i_out_ready = 1'b0;
        i_in_valid  = 1'b1;
        i_instruction = instruction_t'(32'hFE000CE3);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk("bp_in_ready", {31'd0, o_in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, o_out_valid}, 32'd1);
            chk("bp_out_pc", o_out_pc, 32'h110);
            chk("bp_out_imm", o_out_imm, 32'hFFFFFFFC);
            chk("bp_out_read2", o_out_read2, 32'hDEADBEEF);
            @(posedge i_clk);
            #1;
        end
        i_out_ready = 1'b1;
        // beq x0,x0,-8
        issue(32'hFE000CE3, 32'h114, 1'b0, 5'd0, 32'h0,
              '{32'h114, 32'hFFFFFFF8, 32'h0, 32'h0, 5'd0, 5'd0, 5'd25}, st, va);
        // jal x1,8
        issue(32'h008000EF, 32'h118, 1'b0, 5'd0, 32'h0,
              '{32'h118, 32'h8, 32'h0, 32'h0, 5'd0, 5'd8, 5'd1}, st, va);
        // flush with an incoming instruction and an attempted write to x0
        i_in_valid    = 1'b1;
        i_instruction = instruction_t'(32'h00500093);
        i_pc          = 32'h11C;
        i_flush       = 1'b1;
        i_wb_en       = 1'b1;
        i_wb_id       = 5'd0;
        i_wb_data     = 32'h7;
        @(negedge i_clk);
        chk("flush_in_ready", {31'd0, o_in_ready}, 32'd0);
        @(posedge i_clk);
        #1;
        i_flush    = 1'b0;
        i_in_valid = 1'b0;
        i_wb_en    = 1'b0;
        @(negedge i_clk);
        chk("flush_out_valid", {31'd0, o_out_valid}, 32'd0);
        @(posedge i_clk);
        #1;
        // add x8,x0,x0 while again trying to write x0
        issue(32'h00000433, 32'h120, 1'b1, 5'd0, 32'h7,
              '{32'h120, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd8}, st, va);
        repeat (4) @(negedge i_clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
